// File: rtl/nvram_upload_responder.sv
// Answers HPS upload reads of game NVRAM: pauses the CPU, fetches each requested
// byte through a shared RAM port and holds off HPS with ioctl_wait meanwhile.
module nvram_upload_responder #(
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned RAM_LAT    = 1,
  parameter logic [7:0]  UPLOAD_IDX = 8'd4,
  parameter int unsigned ACK_TMO    = 4095
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              ioctl_upload,
  input  logic [7:0]        ioctl_index,
  input  logic              ioctl_rd,
  input  logic [24:0]       ioctl_addr,
  output logic [7:0]        ioctl_din,
  output logic              ioctl_wait,
  output logic              pause_req,
  input  logic              pause_ack,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_rd,
  input  logic [7:0]        ram_q,
  output logic              busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PAUSE,
    S_READY,
    S_FETCH,
    S_DRAIN
  } state_t;

  state_t            state, state_nx;
  logic [11:0]       tmo_cnt, tmo_nx;
  logic [1:0]        lat_cnt;
  logic [ADDR_W-1:0] addr_q;
  logic              act, in_range, tmo_hit, fetch_done;

  assign act        = ioctl_upload && (ioctl_index == UPLOAD_IDX);
  assign in_range   = (ioctl_addr[24:ADDR_W] == '0);
  assign tmo_nx     = (tmo_cnt == '1) ? tmo_cnt : tmo_cnt + 12'd1;
  // Leave PAUSE in the cycle the count reaches ACK_TMO: ACK_TMO cycles of PAUSE.
  assign tmo_hit    = (tmo_nx == 12'(ACK_TMO));
  // lat_cnt is 1 in the first FETCH cycle, i.e. it counts cycles since the ram_rd edge.
  assign fetch_done = (lat_cnt == 2'(RAM_LAT));
  assign busy       = (state != S_IDLE);

  always_comb begin
    state_nx   = state;
    ioctl_wait = 1'b0;
    pause_req  = 1'b0;
    ram_rd     = 1'b0;
    ram_addr   = addr_q;
    case (state)
      S_IDLE: begin
        if (act) state_nx = S_PAUSE;
      end
      S_PAUSE: begin
        pause_req  = 1'b1;
        ioctl_wait = 1'b1;
        if (pause_ack || tmo_hit) state_nx = S_READY;
      end
      S_READY: begin
        pause_req  = 1'b1;
        ioctl_wait = ioctl_rd;
        if (ioctl_rd) begin
          // RAM is strobed in the request cycle so RAM_LAT FETCH cycles suffice.
          if (in_range) begin
            ram_rd   = 1'b1;
            ram_addr = ioctl_addr[ADDR_W-1:0];
            state_nx = S_FETCH;
          end
        end else if (!ioctl_upload) begin
          state_nx = S_DRAIN;
        end
      end
      S_FETCH: begin
        pause_req  = 1'b1;
        ioctl_wait = 1'b1;
        if (fetch_done) state_nx = ioctl_upload ? S_READY : S_DRAIN;
      end
      S_DRAIN: begin
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      tmo_cnt   <= '0;
      lat_cnt   <= '0;
      addr_q    <= '0;
      ioctl_din <= '0;
    end else begin
      state   <= state_nx;
      tmo_cnt <= (state == S_PAUSE) ? tmo_nx : '0;
      if (state == S_READY && ioctl_rd) begin
        if (in_range) begin
          addr_q  <= ioctl_addr[ADDR_W-1:0];
          lat_cnt <= 2'd1;
        end else begin
          ioctl_din <= 8'hFF;
        end
      end
      if (state == S_FETCH) begin
        lat_cnt <= lat_cnt + 2'd1;
        if (fetch_done) ioctl_din <= ram_q;
      end
    end
  end

endmodule
